alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, which sets the operand, result and register width.
REQ-002 The block SHALL have parameter REG_AW, default 3, which sets the register address width (8 registers).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port instr_valid, input, 1 bit: an instruction word is offered.
REQ-006 The block SHALL have port instr, input, 16 bits: op[15:13], rd[12:10], rs[9:7], rt[6:4], [3:0] ignored.
REQ-007 The block SHALL have port instr_ready, output, 1 bit: the block accepts instr this cycle.
REQ-008 The block SHALL have port alu_x, output, DATA_W bits: ALU operand X, driven from register rs.
REQ-009 The block SHALL have port alu_y, output, DATA_W bits: ALU operand Y, driven from register rt.
REQ-010 The block SHALL have port alu_op, output, 3 bits: ALU opcode.
REQ-011 The block SHALL have port alu_cin, output, 1 bit: ALU carry-in.
REQ-012 The block SHALL have port alu_out, input, DATA_W bits: combinational ALU result.
REQ-013 The block SHALL have port alu_cout, input, 1 bit: ALU carry-out.
REQ-014 The block SHALL have port wb_valid, output, 1 bit: one-cycle pulse when a result is written back.
REQ-015 The block SHALL have port wb_addr, output, REG_AW bits: destination register of the writeback.
REQ-016 The block SHALL have port wb_data, output, DATA_W bits: value written back.
REQ-017 The block SHALL have ports flag_lt, flag_eq, flag_gt and flag_c, outputs, 1 bit each: sticky flags from the last completed operation.
REQ-018 The block SHALL have port illegal, output, 1 bit: one-cycle pulse when an undefined opcode is accepted.

Function
REQ-019 The FSM SHALL have the states IDLE, ISSUE, CAPTURE and WRITEBACK.
REQ-020 instr_ready SHALL be 1 only in IDLE.
REQ-021 A transfer SHALL occur when instr_valid and instr_ready are both 1; the FSM then moves IDLE->ISSUE and latches the instruction.
REQ-022 Legal opcodes SHALL be 000 AND, 001 OR, 010 ADD, 110 SUB and 111 SLT.
REQ-023 An accepted opcode of 011, 100 or 101 SHALL pulse illegal in the next cycle, return the FSM to IDLE, perform no writeback and leave the flags unchanged.
REQ-024 In ISSUE, alu_x SHALL equal reg[rs], alu_y SHALL equal reg[rt], alu_op SHALL equal op, and alu_cin SHALL be 1 for SUB and 0 otherwise; the FSM then moves to CAPTURE.
REQ-025 The ALU outputs SHALL be held stable from ISSUE through CAPTURE.
REQ-026 In CAPTURE, the block SHALL register alu_out, and flag_c SHALL take the value of alu_cout.
REQ-027 In CAPTURE, flag_lt, flag_eq and flag_gt SHALL be set from a signed compare of alu_x against alu_y, with exactly one of the three set; the FSM then moves to WRITEBACK.
REQ-028 In WRITEBACK, the block SHALL write the captured result to reg[rd], pulse wb_valid for one cycle with wb_addr=rd and wb_data=result, and then move to IDLE.
REQ-029 Latency SHALL be: handshake at cycle N, ALU driven at cycle N+1, capture at N+2, wb_valid at N+3, and instr_ready high again at N+4.
REQ-030 Register 0 SHALL always read as 0; a write to rd=0 SHALL still pulse wb_valid (wb_addr=0, wb_data=result) but SHALL leave reg[0] at 0.
REQ-031 When rs=rd or rt=rd, the operands SHALL be the pre-write values.
REQ-032 instr_valid deasserted while instr_ready=1 SHALL leave the FSM in IDLE; instr_valid held high outside IDLE SHALL be ignored.
REQ-033 Arithmetic SHALL be modulo 2^DATA_W; overflow is visible only through flag_c.

Reset
REQ-034 When rst=1 at a clock edge, the FSM SHALL go to IDLE from any state and discard any in-flight instruction, with no writeback.
REQ-035 During and after reset, wb_valid, illegal, all flags, alu_x, alu_y, alu_op and alu_cin SHALL be 0, and instr_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-036 Reset SHALL clear all registers to 0.

Structure
REQ-037 A shared package alu_pkg SHALL hold the opcode constants (OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT) and the FSM state encoding.
REQ-038 The block SHALL instantiate one sub-module, regfile_8x16, which has two combinational read ports, one synchronous write port, a hardwired-zero r0 and a synchronous clear.
REQ-039 The ALU SHALL stay external, connected only through the alu_* ports.

Verification
REQ-040 The bench SHALL cover: reset, then ADD with r1=0x0003, r2=0x0004, rd=r3 -> wb_valid at N+3, wb_addr=3, wb_data=0x0007, flag_lt=1.
REQ-041 The bench SHALL cover: ADD with 0xFFFF+0x0001 into r4 -> wb_data=0x0000, flag_c=1.
REQ-042 The bench SHALL cover: opcode 100 accepted -> illegal pulses one cycle, no wb_valid, flags unchanged, instr_ready=1 two cycles after acceptance.
REQ-043 The bench SHALL cover: rst asserted during CAPTURE -> no wb_valid, registers=0, instr_ready=1 on the cycle after rst deasserts.
REQ-044 The bench SHALL cover: write to rd=0 -> wb_valid pulses, and a following read of r0 returns 0x0000.
REQ-045 The bench SHALL cover: instr_valid held high continuously -> instructions accepted exactly once every 4 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue controller: opcode encodings,
// FSM state encoding and the opcode legality helper.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    CAPTURE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  // 011, 100 and 101 are undefined; everything else maps to an ALU function.
  function automatic logic op_is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: legal = 1'b1;
      default:                               legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/regfile_8x16.sv
// Register file: two combinational read ports, one synchronous write port,
// register 0 hardwired to zero, synchronous clear of every entry.
module regfile_8x16 #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              i_clr,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  output logic [DATA_W-1:0] o_rdata_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] r_mem [NREG];

  // Storage update: clear wins over write; writes to entry 0 are dropped.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else if (i_we && (i_waddr != {REG_AW{1'b0}})) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : r_mem[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == {REG_AW{1'b0}}) ? {DATA_W{1'b0}} : r_mem[i_raddr_b];

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one instruction at a time, drives an
// external ALU from the register file, captures its result and flags and
// writes the result back. One instruction occupies four cycles.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [2:0]        alu_op,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              flag_lt,
  output logic              flag_eq,
  output logic              flag_gt,
  output logic              flag_c,
  output logic              illegal
);

  state_t r_state;
  state_t w_state_nxt;

  logic [2:0]        w_op;
  logic [REG_AW-1:0] w_rd;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic              w_accept;
  logic              w_unused_bits;
  logic [DATA_W-1:0] w_rdata_x;
  logic [DATA_W-1:0] w_rdata_y;
  logic              w_we;

  logic              r_legal;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_alu_x;
  logic [DATA_W-1:0] r_alu_y;
  logic [2:0]        r_alu_op;
  logic              r_alu_cin;
  logic              r_wb_valid;
  logic [REG_AW-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_flag_lt;
  logic              r_flag_eq;
  logic              r_flag_gt;
  logic              r_flag_c;
  logic              r_illegal;

  // Instruction field decode; the low nibble carries no meaning.
  assign w_op          = instr[15:13];
  assign w_rd          = REG_AW'(instr[12:10]);
  assign w_rs          = REG_AW'(instr[9:7]);
  assign w_rt          = REG_AW'(instr[6:4]);
  assign w_unused_bits = ^instr[3:0];

  assign instr_ready = (r_state == IDLE);
  assign w_accept    = instr_valid && instr_ready;

  // Result is committed during the writeback cycle, so operands read for
  // the next instruction (accepted no earlier than the following cycle)
  // already see it, and operands of the current one were read before it.
  assign w_we = (r_state == WRITEBACK);

  regfile_8x16 #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk       (clk),
    .i_clr     (rst),
    .i_we      (w_we),
    .i_waddr   (r_wb_addr),
    .i_wdata   (r_wb_data),
    .i_raddr_a (w_rs),
    .o_rdata_a (w_rdata_x),
    .i_raddr_b (w_rt),
    .o_rdata_b (w_rdata_y)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode; an illegal opcode leaves ISSUE straight to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (r_legal) begin
          w_state_nxt = CAPTURE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      CAPTURE:   w_state_nxt = WRITEBACK;
      WRITEBACK: w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch the instruction and operands on accept, capture the
  // ALU result and flags, and generate the writeback / illegal pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_legal    <= 1'b0;
      r_rd       <= {REG_AW{1'b0}};
      r_alu_x    <= {DATA_W{1'b0}};
      r_alu_y    <= {DATA_W{1'b0}};
      r_alu_op   <= 3'b000;
      r_alu_cin  <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_addr  <= {REG_AW{1'b0}};
      r_wb_data  <= {DATA_W{1'b0}};
      r_flag_lt  <= 1'b0;
      r_flag_eq  <= 1'b0;
      r_flag_gt  <= 1'b0;
      r_flag_c   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      r_illegal  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rd    <= w_rd;
            r_legal <= op_is_legal(w_op);
            if (op_is_legal(w_op)) begin
              r_alu_x   <= w_rdata_x;
              r_alu_y   <= w_rdata_y;
              r_alu_op  <= w_op;
              r_alu_cin <= (w_op == OP_SUB);
            end else begin
              r_illegal <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          r_wb_data  <= alu_out;
          r_wb_addr  <= r_rd;
          r_wb_valid <= 1'b1;
          r_flag_c   <= alu_cout;
          r_flag_lt  <= ($signed(r_alu_x) <  $signed(r_alu_y));
          r_flag_eq  <= (r_alu_x == r_alu_y);
          r_flag_gt  <= ($signed(r_alu_x) >  $signed(r_alu_y));
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_x    = r_alu_x;
  assign alu_y    = r_alu_y;
  assign alu_op   = r_alu_op;
  assign alu_cin  = r_alu_cin;
  assign wb_valid = r_wb_valid;
  assign wb_addr  = r_wb_addr;
  assign wb_data  = r_wb_data;
  assign flag_lt  = r_flag_lt;
  assign flag_eq  = r_flag_eq;
  assign flag_gt  = r_flag_gt;
  assign flag_c   = r_flag_c;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: provides the external ALU (with an override
// used to load register values), keeps a reference register file and a
// scoreboard of expected writebacks / illegal pulses.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          instr_valid = 1'b0;
  logic [15:0]   instr = 16'h0000;
  logic          instr_ready;
  logic [DW-1:0] alu_x, alu_y, alu_out;
  logic [2:0]    alu_op;
  logic          alu_cin, alu_cout;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          flag_lt, flag_eq, flag_gt, flag_c, illegal;

  alu_issue_ctrl #(.DATA_W(DW), .REG_AW(AW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .instr_ready(instr_ready), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
    .alu_cin(alu_cin), .alu_out(alu_out), .alu_cout(alu_cout),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .flag_lt(flag_lt), .flag_eq(flag_eq), .flag_gt(flag_gt), .flag_c(flag_c),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference ALU: carry-in fixed by opcode (1 only for SUB).
  function automatic logic [DW:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW:0] s;
    case (op)
      OP_AND:  s = {1'b0, x & y};
      OP_OR:   s = {1'b0, x | y};
      OP_ADD:  s = {1'b0, x} + {1'b0, y};
      OP_SUB:  s = {1'b0, x} + {1'b0, ~y} + {{DW{1'b0}}, 1'b1};
      OP_SLT:  s = {{DW{1'b0}}, ($signed(x) < $signed(y))};
      default: s = '0;
    endcase
    return s;
  endfunction

  // External ALU as seen by the DUT; uses the DUT's carry-in.
  logic          inj_en = 1'b0;
  logic [DW-1:0] inj_val = '0;
  logic          inj_c = 1'b0;
  logic [DW:0]   alu_sum;
  always_comb begin
    alu_sum = '0;
    case (alu_op)
      OP_AND:        alu_sum = {1'b0, alu_x & alu_y};
      OP_OR:         alu_sum = {1'b0, alu_x | alu_y};
      OP_ADD, OP_SUB: alu_sum = {1'b0, alu_x} + {1'b0, (alu_op == OP_SUB) ? ~alu_y : alu_y}
                               + {{DW{1'b0}}, alu_cin};
      OP_SLT:        alu_sum = {{DW{1'b0}}, ($signed(alu_x) < $signed(alu_y))};
      default:       alu_sum = '0;
    endcase
    if (inj_en) alu_sum = {inj_c, inj_val};
  end
  assign alu_out  = alu_sum[DW-1:0];
  assign alu_cout = alu_sum[DW];

  typedef struct {
    bit            ill;
    int            due;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [2:0]    op;
    logic [3:0]    flags;  // {lt, eq, gt, c}
  } exp_t;

  exp_t          sb[$];
  exp_t          e_new;
  logic [DW-1:0] mreg [8];
  logic [3:0]    mflags = 4'b0000;
  logic [DW:0]   res;
  int            ready_due = -1;
  bit            due_wb, due_il;
  logic [AW-1:0] last_wb_addr = '0;
  logic [DW-1:0] last_wb_data = '0;
  int            n_wb = 0, n_ill = 0;
  bit            stream_on = 1'b0;
  int            last_acc = -1, n_stream_acc = 0;

  // Monitor: compare DUT outputs against the scoreboard at every falling edge.
  initial begin
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ready_due == cyc) check_eq("ready_return", 64'(instr_ready), 64'd1);
        due_wb = (sb.size() > 0) && !sb[0].ill && (sb[0].due == cyc);
        due_il = (sb.size() > 0) &&  sb[0].ill && (sb[0].due == cyc);
        if (sb.size() > 0 && !sb[0].ill && cyc == sb[0].due - 2) begin
          check_eq("issue_x",     64'(alu_x),   64'(sb[0].x));
          check_eq("issue_y",     64'(alu_y),   64'(sb[0].y));
          check_eq("issue_op",    64'(alu_op),  64'(sb[0].op));
          check_eq("issue_cin",   64'(alu_cin), 64'(sb[0].op == OP_SUB));
          check_eq("issue_ready", 64'(instr_ready), 64'd0);
        end
        if (sb.size() > 0 && !sb[0].ill && cyc == sb[0].due - 1) begin
          check_eq("capture_x", 64'(alu_x), 64'(sb[0].x));
          check_eq("capture_y", 64'(alu_y), 64'(sb[0].y));
        end
        if (due_wb) begin
          check_eq("wb_valid", 64'(wb_valid), 64'd1);
          check_eq("wb_addr",  64'(wb_addr),  64'(sb[0].rd));
          check_eq("wb_data",  64'(wb_data),  64'(sb[0].data));
          check_eq("wb_flags", 64'({flag_lt, flag_eq, flag_gt, flag_c}), 64'(sb[0].flags));
          if (sb[0].rd != '0) mreg[sb[0].rd] = sb[0].data;
          mflags       = sb[0].flags;
          last_wb_addr = wb_addr;
          last_wb_data = wb_data;
          void'(sb.pop_front());
        end else begin
          check_eq("wb_quiet", 64'(wb_valid), 64'd0);
        end
        if (wb_valid) n_wb++;
        if (due_il) begin
          check_eq("illegal_pulse", 64'(illegal), 64'd1);
          check_eq("illegal_flags", 64'({flag_lt, flag_eq, flag_gt, flag_c}), 64'(mflags));
          void'(sb.pop_front());
        end else begin
          check_eq("illegal_quiet", 64'(illegal), 64'd0);
        end
        if (illegal) n_ill++;
        if (instr_valid && instr_ready) begin
          e_new.op  = instr[15:13];
          e_new.ill = (e_new.op == 3'b011) || (e_new.op == 3'b100) || (e_new.op == 3'b101);
          e_new.rd  = instr[12:10];
          e_new.x   = mreg[instr[9:7]];
          e_new.y   = mreg[instr[6:4]];
          res       = inj_en ? {inj_c, inj_val} : alu_ref(e_new.op, e_new.x, e_new.y);
          e_new.data  = res[DW-1:0];
          e_new.flags = {($signed(e_new.x) < $signed(e_new.y)), (e_new.x == e_new.y),
                         ($signed(e_new.x) > $signed(e_new.y)), res[DW]};
          e_new.due = e_new.ill ? cyc + 1 : cyc + 3;
          ready_due = e_new.ill ? cyc + 2 : cyc + 4;
          sb.push_back(e_new);
          if (stream_on) begin
            if (last_acc >= 0) check_eq("stream_gap", 64'(cyc - last_acc), 64'd4);
            last_acc = cyc;
            n_stream_acc++;
          end
        end
      end
    end
  end

  // Offer one instruction, wait (bounded) for acceptance and completion.
  task automatic issue(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs,
                       input logic [2:0] rt, input bit ie, input logic [DW-1:0] iv, input bit ic);
    int n = 0;
    @(posedge clk); #1;
    inj_en = ie; inj_val = iv; inj_c = ic;
    instr = {op, rd, rs, rt, 4'b0101};
    instr_valid = 1'b1;
    @(negedge clk);
    while (!instr_ready && n < 50) begin @(negedge clk); n++; end
    check_eq("accept_wait", 64'(instr_ready), 64'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check_eq("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
    inj_en = 1'b0;
  endtask

  // Apply reset for one edge, check quiescent outputs, release and clear the model.
  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("rst_pulses", 64'({wb_valid, illegal}), 64'd0);
    check_eq("rst_flags",  64'({flag_lt, flag_eq, flag_gt, flag_c}), 64'd0);
    check_eq("rst_alu",    64'({alu_cin, alu_op, alu_x, alu_y}), 64'd0);
    #2 rst = 1'b0;
    sb.delete();
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    mflags = 4'b0000;
    ready_due = -1;
    @(negedge clk);
    check_eq("ready_after_rst", 64'(instr_ready), 64'd1);
    check_eq("wb_after_rst",    64'(wb_valid),    64'd0);
  endtask

  initial begin
    int wb0, ill0;
    do_reset();

    // Load r1=3, r2=4 through the ALU override, then ADD r3 = r1 + r2.
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0003, 1'b0);
    issue(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'h0004, 1'b0);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0);
    check_eq("add_r3_addr", 64'(last_wb_addr), 64'd3);
    check_eq("add_r3_data", 64'(last_wb_data), 64'h0007);
    check_eq("add_r3_lt",   64'(flag_lt),      64'd1);

    // Wrap-around: 0xFFFF + 0x0001 into r4.
    issue(OP_ADD, 3'd5, 3'd0, 3'd0, 1'b1, 16'hFFFF, 1'b0);
    issue(OP_ADD, 3'd6, 3'd0, 3'd0, 1'b1, 16'h0001, 1'b0);
    issue(OP_ADD, 3'd4, 3'd5, 3'd6, 1'b0, 16'h0000, 1'b0);
    check_eq("ovf_data", 64'(last_wb_data), 64'h0000);
    check_eq("ovf_c",    64'(flag_c),       64'd1);

    // Undefined opcode 100: one illegal pulse, no writeback, flags kept.
    wb0 = n_wb; ill0 = n_ill;
    issue(3'b100, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0);
    check_eq("illegal_count", 64'(n_ill - ill0), 64'd1);
    check_eq("illegal_no_wb", 64'(n_wb - wb0),   64'd0);
    check_eq("illegal_flags_kept", 64'({flag_lt, flag_eq, flag_gt, flag_c}), 64'b1001);

    // Remaining ALU functions, including a same-register source/dest.
    issue(OP_SUB, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0);
    check_eq("sub_data", 64'(last_wb_data), 64'hFFFF);
    issue(OP_SLT, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0);
    issue(OP_AND, 3'd7, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0);
    issue(OP_OR,  3'd7, 3'd1, 3'd2, 1'b0, 16'h0000, 1'b0);
    issue(OP_SUB, 3'd2, 3'd2, 3'd1, 1'b0, 16'h0000, 1'b0);
    check_eq("self_sub_data", 64'(last_wb_data), 64'h0001);

    // Write to r0 still pulses writeback but r0 keeps reading zero.
    issue(OP_ADD, 3'd0, 3'd1, 3'd3, 1'b0, 16'h0000, 1'b0);
    check_eq("r0_wb_addr", 64'(last_wb_addr), 64'd0);
    check_eq("r0_wb_data", 64'(last_wb_data), 64'h000A);
    issue(OP_OR, 3'd3, 3'd0, 3'd0, 1'b0, 16'h0000, 1'b0);
    check_eq("r0_reads_zero", 64'(last_wb_data), 64'h0000);

    // Reset while the instruction sits in CAPTURE.
    wb0 = n_wb;
    @(posedge clk); #1;
    instr = {OP_ADD, 3'd3, 3'd1, 3'd7, 4'h0};
    instr_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 instr_valid = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_capture_no_wb", 64'(n_wb - wb0), 64'd0);
    issue(OP_OR, 3'd5, 3'd1, 3'd7, 1'b0, 16'h0000, 1'b0);
    check_eq("regs_cleared", 64'(last_wb_data), 64'h0000);

    // instr_valid held high: one acceptance every four cycles.
    issue(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h0005, 1'b0);
    @(posedge clk); #1;
    instr = {OP_ADD, 3'd6, 3'd6, 3'd1, 4'h0};
    last_acc = -1; n_stream_acc = 0;
    stream_on = 1'b1;
    instr_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (6) @(negedge clk);
    stream_on = 1'b0;
    check_eq("stream_accepts", 64'(n_stream_acc), 64'd5);
    check_eq("stream_result",  64'(last_wb_data), 64'h0019);
    check_eq("stream_drained", 64'(sb.size()),    64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
